// File: rtl/mem_access_ctrl.sv
// Single-port arbiter/sequencer between the RV32I core's fetch and load/store
// channels and a memory with one-cycle registered read latency.
//
// Handshake: a request is taken in the cycle where req && ready; ready is only
// high in IDLE outside reset. The response is a one-cycle valid pulse in the
// next cycle, and the data output holds the last response value afterwards.
module mem_access_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_ready,
    output logic        if_valid,
    output logic [31:0] if_instr,
    output logic        if_err,
    input  logic        ls_req,
    input  logic        ls_we,
    input  logic [2:0]  ls_funct3,
    input  logic [31:0] ls_addr,
    input  logic [31:0] ls_wdata,
    output logic        ls_ready,
    output logic        ls_valid,
    output logic [31:0] ls_rdata,
    output logic        ls_err,
    output logic        mem_write,
    output logic [2:0]  mem_funct3,
    output logic [31:0] mem_write_address,
    output logic [31:0] mem_write_data,
    output logic [31:0] mem_read_address,
    input  logic [31:0] mem_read_data,
    output logic [2:0]  dbg_state_o
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        RESP_F = 3'd1,
        RESP_L = 3'd2,
        RESP_S = 3'd3,
        RESP_E = 3'd4
    } state_t;

    state_t      state_q;
    logic        err_fetch_q;
    logic [31:0] if_hold_q;
    logic [31:0] ls_hold_q;

    logic idle;
    logic accept_ls;
    logic accept_if;
    logic ls_misal;
    logic if_misal;

    assign idle      = (state_q == IDLE);
    assign ls_ready  = idle && rst_n;
    assign if_ready  = idle && !ls_req && rst_n;
    assign accept_ls = ls_req && ls_ready;
    assign accept_if = if_req && if_ready;
    assign if_misal  = (if_addr[1:0] != 2'b00);

    // funct3[1] marks a word access, funct3[1:0] == 01 a halfword; bytes never fault.
    always_comb begin
        ls_misal = 1'b0;
        if (ls_funct3[1]) begin
            ls_misal = (ls_addr[1:0] != 2'b00);
        end else if (ls_funct3[1:0] == 2'b01) begin
            ls_misal = ls_addr[0];
        end
    end

    always_comb begin
        mem_write         = 1'b0;
        mem_funct3        = 3'b010;
        mem_write_address = 32'd0;
        mem_write_data    = 32'd0;
        mem_read_address  = 32'd0;
        if (accept_ls && !ls_misal) begin
            mem_funct3 = ls_funct3;
            if (ls_we) begin
                mem_write         = 1'b1;
                mem_write_address = ls_addr;
                mem_write_data    = ls_wdata;
            end else begin
                mem_read_address = ls_addr;
            end
        end else if (accept_if && !if_misal) begin
            mem_read_address = if_addr;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            err_fetch_q <= 1'b0;
            if_hold_q   <= 32'd0;
            ls_hold_q   <= 32'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept_ls) begin
                        err_fetch_q <= 1'b0;
                        if (ls_misal) begin
                            state_q <= RESP_E;
                        end else if (ls_we) begin
                            state_q <= RESP_S;
                        end else begin
                            state_q <= RESP_L;
                        end
                    end else if (accept_if) begin
                        err_fetch_q <= 1'b1;
                        state_q     <= if_misal ? RESP_E : RESP_F;
                    end
                end
                RESP_F: begin
                    if_hold_q <= mem_read_data;
                    state_q   <= IDLE;
                end
                RESP_L: begin
                    ls_hold_q <= mem_read_data;
                    state_q   <= IDLE;
                end
                RESP_S: begin
                    state_q <= IDLE;
                end
                RESP_E: begin
                    if (err_fetch_q) begin
                        if_hold_q <= 32'd0;
                    end else begin
                        ls_hold_q <= 32'd0;
                    end
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Response outputs are forced to their idle values while reset is low so a
    // response in flight when reset arrives is never seen by the core.
    always_comb begin
        if_valid = 1'b0;
        if_err   = 1'b0;
        if_instr = 32'd0;
        ls_valid = 1'b0;
        ls_err   = 1'b0;
        ls_rdata = 32'd0;
        if (rst_n) begin
            if_instr = if_hold_q;
            ls_rdata = ls_hold_q;
            case (state_q)
                RESP_F: begin
                    if_valid = 1'b1;
                    if_instr = mem_read_data;
                end
                RESP_L: begin
                    ls_valid = 1'b1;
                    ls_rdata = mem_read_data;
                end
                RESP_S: begin
                    ls_valid = 1'b1;
                end
                RESP_E: begin
                    if (err_fetch_q) begin
                        if_valid = 1'b1;
                        if_err   = 1'b1;
                        if_instr = 32'd0;
                    end else begin
                        ls_valid = 1'b1;
                        ls_err   = 1'b1;
                        ls_rdata = 32'd0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: byte-addressed memory with registered reads,
// a vector table, directed multi-cycle sequences and a randomized scoreboard.
module tb_mem_access_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_ready, if_valid, if_err;
    logic [31:0] if_instr;
    logic        ls_req, ls_we;
    logic [2:0]  ls_funct3;
    logic [31:0] ls_addr, ls_wdata;
    logic        ls_ready, ls_valid, ls_err;
    logic [31:0] ls_rdata;
    logic        mem_write;
    logic [2:0]  mem_funct3;
    logic [31:0] mem_write_address, mem_write_data, mem_read_address;
    logic [31:0] mem_read_data = 32'd0;
    logic [2:0]  dbg_state;

    always #5 clk = ~clk;

    mem_access_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready),
        .if_valid(if_valid), .if_instr(if_instr), .if_err(if_err),
        .ls_req(ls_req), .ls_we(ls_we), .ls_funct3(ls_funct3),
        .ls_addr(ls_addr), .ls_wdata(ls_wdata), .ls_ready(ls_ready),
        .ls_valid(ls_valid), .ls_rdata(ls_rdata), .ls_err(ls_err),
        .mem_write(mem_write), .mem_funct3(mem_funct3),
        .mem_write_address(mem_write_address), .mem_write_data(mem_write_data),
        .mem_read_address(mem_read_address), .mem_read_data(mem_read_data),
        .dbg_state_o(dbg_state)
    );

    int total = 0;
    int bad   = 0;

    logic [7:0] bmem [logic [31:0]];
    logic [7:0] rmem [logic [31:0]];

    function automatic logic [7:0] bget(input logic [31:0] a);
        return bmem.exists(a) ? bmem[a] : 8'h00;
    endfunction

    function automatic logic [7:0] rget(input logic [31:0] a);
        return rmem.exists(a) ? rmem[a] : 8'h00;
    endfunction

    function automatic logic [31:0] shape(input logic [2:0] f3, input logic [7:0] b0,
                                          input logic [7:0] b1, input logic [7:0] b2,
                                          input logic [7:0] b3);
        case (f3)
            3'b000:  return {{24{b0[7]}}, b0};
            3'b001:  return {{16{b1[7]}}, b1, b0};
            3'b100:  return {24'd0, b0};
            3'b101:  return {16'd0, b1, b0};
            default: return {b3, b2, b1, b0};
        endcase
    endfunction

    function automatic logic [31:0] mem_load(input logic [2:0] f3, input logic [31:0] a);
        return shape(f3, bget(a), bget(a + 32'd1), bget(a + 32'd2), bget(a + 32'd3));
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] a);
        return shape(f3, rget(a), rget(a + 32'd1), rget(a + 32'd2), rget(a + 32'd3));
    endfunction

    function automatic int store_bytes(input logic [2:0] f3);
        return (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    endfunction

    // Memory model: reads are registered, writes land on the same edge.
    always @(posedge clk) begin
        mem_read_data <= mem_load(mem_funct3, mem_read_address);
        if (mem_write) begin
            for (int i = 0; i < store_bytes(mem_funct3); i++) begin
                bmem[mem_write_address + 32'(i)] = mem_write_data[8*i +: 8];
            end
        end
    end

    function automatic bit misaligned(input bit fetch, input logic [2:0] f3, input logic [31:0] a);
        if (fetch)                return a[1:0] != 2'b00;
        if (f3[1])                return a[1:0] != 2'b00;
        if (f3[1:0] == 2'b01)     return a[0];
        return 1'b0;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic put_word(input logic [31:0] a, input logic [31:0] w);
        for (int i = 0; i < 4; i++) bmem[a + 32'(i)] = w[8*i +: 8];
    endtask

    task automatic drive_idle();
        if_req = 1'b0; ls_req = 1'b0; ls_we = 1'b0;
        ls_funct3 = 3'b010; if_addr = $urandom; ls_addr = $urandom; ls_wdata = $urandom;
    endtask

    task automatic chk_quiet_mem(input string tag);
        chk({tag, "_mem_write"}, 32'(mem_write), 32'd0);
        chk({tag, "_mem_funct3"}, 32'(mem_funct3), 32'd2);
        chk({tag, "_mem_addrs"}, mem_read_address | mem_write_address | mem_write_data, 32'd0);
    endtask

    typedef struct {
        bit          fetch;
        bit          we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        bit          exp_err;
        logic [31:0] exp_data;
    } vec_t;

    vec_t vecs[$];

    task automatic run_vec(input vec_t v, input int idx);
        bit    mis;
        string t;
        t   = $sformatf("vec%0d", idx);
        mis = misaligned(v.fetch, v.f3, v.addr);
        @(posedge clk); #1;
        if (v.fetch) begin
            if_req = 1'b1; if_addr = v.addr;
        end else begin
            ls_req = 1'b1; ls_we = v.we; ls_funct3 = v.f3; ls_addr = v.addr; ls_wdata = v.wdata;
        end
        @(negedge clk);
        chk({t, "_ready"}, 32'(v.fetch ? if_ready : ls_ready), 32'd1);
        chk({t, "_mem_write"}, 32'(mem_write), 32'(!v.fetch && v.we && !mis));
        chk({t, "_mem_raddr"}, mem_read_address, (!mis && (v.fetch || !v.we)) ? v.addr : 32'd0);
        chk({t, "_mem_waddr"}, mem_write_address, (!mis && !v.fetch && v.we) ? v.addr : 32'd0);
        chk({t, "_mem_wdata"}, mem_write_data, (!mis && !v.fetch && v.we) ? v.wdata : 32'd0);
        chk({t, "_mem_funct3"}, 32'(mem_funct3), (mis || v.fetch) ? 32'd2 : 32'(v.f3));
        @(posedge clk); #1;
        drive_idle();
        @(negedge clk);
        chk({t, "_valid"}, 32'(v.fetch ? if_valid : ls_valid), 32'd1);
        chk({t, "_other_valid"}, 32'(v.fetch ? ls_valid : if_valid), 32'd0);
        chk({t, "_err"}, 32'(v.fetch ? if_err : ls_err), 32'(v.exp_err));
        chk({t, "_data"}, v.fetch ? if_instr : ls_rdata, v.exp_data);
        chk({t, "_resp_ready"}, 32'({if_ready, ls_ready}), 32'd0);
        chk({t, "_resp_mem_write"}, 32'(mem_write), 32'd0);
        @(negedge clk);
        chk({t, "_hold"}, v.fetch ? if_instr : ls_rdata, v.exp_data);
        chk({t, "_hold_valid"}, 32'({if_valid, ls_valid}), 32'd0);
    endtask

    localparam int W = 34;
    logic [W-1:0] exp_q[$];

    task automatic run_random(input int cycles);
        logic [2:0]  ld_f3 [5];
        logic [31:0] m_if_hold, m_ls_hold;
        logic [W-1:0] e;
        bit          m_busy, mis;
        logic [31:0] data;
        ld_f3 = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        m_if_hold = 32'd0; m_ls_hold = 32'd0; m_busy = 1'b0;
        for (int c = 0; c < cycles; c++) begin
            @(posedge clk); #1;
            if_req  = ($urandom_range(0, 2) != 0);
            ls_req  = ($urandom_range(0, 2) == 0);
            ls_we   = $urandom_range(0, 1);
            ls_funct3 = ls_we ? 3'($urandom_range(0, 2)) : ld_f3[$urandom_range(0, 4)];
            ls_addr = 32'h100 + 32'($urandom_range(0, 28));
            ls_wdata = $urandom;
            if_addr = 32'h100 + 32'($urandom_range(0, 7) * 4)
                      + (($urandom_range(0, 3) == 0) ? 32'($urandom_range(1, 3)) : 32'd0);
            @(negedge clk);
            if (m_busy) begin
                e = exp_q.pop_front();
                chk("rnd_if_valid", 32'(if_valid), 32'(!e[33]));
                chk("rnd_ls_valid", 32'(ls_valid), 32'(e[33]));
                chk("rnd_err", 32'({if_err, ls_err}), e[33] ? 32'(e[32]) : 32'({e[32], 1'b0}));
            end else begin
                chk("rnd_idle_flags", 32'({if_valid, ls_valid, if_err, ls_err}), 32'd0);
            end
            chk("rnd_if_instr", if_instr, m_if_hold);
            chk("rnd_ls_rdata", ls_rdata, m_ls_hold);
            chk("rnd_ls_ready", 32'(ls_ready), 32'(!m_busy));
            chk("rnd_if_ready", 32'(if_ready), 32'(!m_busy && !ls_req));
            if (!m_busy && ls_req) begin
                mis = misaligned(1'b0, ls_funct3, ls_addr);
                if (mis) begin
                    data = 32'd0; m_ls_hold = 32'd0;
                end else if (ls_we) begin
                    for (int i = 0; i < store_bytes(ls_funct3); i++)
                        rmem[ls_addr + 32'(i)] = ls_wdata[8*i +: 8];
                    data = m_ls_hold;
                end else begin
                    data = ref_load(ls_funct3, ls_addr); m_ls_hold = data;
                end
                exp_q.push_back({1'b1, mis, data});
                chk("rnd_mem_write", 32'(mem_write), 32'(ls_we && !mis));
                chk("rnd_mem_raddr", mem_read_address, (!mis && !ls_we) ? ls_addr : 32'd0);
                chk("rnd_mem_waddr", mem_write_address, (!mis && ls_we) ? ls_addr : 32'd0);
                chk("rnd_mem_funct3", 32'(mem_funct3), mis ? 32'd2 : 32'(ls_funct3));
                m_busy = 1'b1;
            end else if (!m_busy && if_req) begin
                mis = misaligned(1'b1, 3'b010, if_addr);
                data = mis ? 32'd0 : ref_load(3'b010, if_addr);
                m_if_hold = data;
                exp_q.push_back({1'b0, mis, data});
                chk("rnd_fetch_raddr", mem_read_address, mis ? 32'd0 : if_addr);
                chk("rnd_fetch_mem_write", 32'(mem_write), 32'd0);
                m_busy = 1'b1;
            end else begin
                chk_quiet_mem("rnd_quiet");
                m_busy = 1'b0;
            end
        end
    endtask

    initial begin
        put_word(32'h10, 32'h00A00093);
        put_word(32'h20, 32'hDEADBEEF);
        put_word(32'h40, 32'h11223344);
        for (int a = 32'h100; a < 32'h120; a++) begin
            bmem[32'(a)] = 8'($urandom);
            rmem[32'(a)] = bmem[32'(a)];
        end

        vecs.push_back('{0, 0, 3'b010, 32'h40, 32'h0, 0, 32'h11223344});
        vecs.push_back('{1, 0, 3'b010, 32'h10, 32'h0, 0, 32'h00A00093});
        vecs.push_back('{0, 0, 3'b010, 32'h20, 32'h0, 0, 32'hDEADBEEF});
        vecs.push_back('{0, 1, 3'b000, 32'h21, 32'hABCDEFFF, 0, 32'hDEADBEEF});
        vecs.push_back('{0, 0, 3'b000, 32'h21, 32'h0, 0, 32'hFFFFFFFF});
        vecs.push_back('{0, 0, 3'b100, 32'h21, 32'h0, 0, 32'h000000FF});
        vecs.push_back('{0, 0, 3'b010, 32'h22, 32'h0, 1, 32'h0});
        vecs.push_back('{0, 1, 3'b001, 32'h23, 32'h5555, 1, 32'h0});
        vecs.push_back('{0, 0, 3'b010, 32'h20, 32'h0, 0, 32'hDEADFFEF});
        vecs.push_back('{1, 0, 3'b010, 32'h06, 32'h0, 1, 32'h0});
        vecs.push_back('{0, 1, 3'b010, 32'hFFFFFFFC, 32'h80402010, 0, 32'hDEADFFEF});
        vecs.push_back('{0, 0, 3'b010, 32'hFFFFFFFC, 32'h0, 0, 32'h80402010});
        vecs.push_back('{0, 0, 3'b001, 32'h22, 32'h0, 0, 32'hFFFFDEAD});
        vecs.push_back('{0, 0, 3'b101, 32'h22, 32'h0, 0, 32'h0000DEAD});
        vecs.push_back('{0, 0, 3'b001, 32'h21, 32'h0, 1, 32'h0});
        vecs.push_back('{0, 1, 3'b001, 32'h22, 32'h00001234, 0, 32'h0});
        vecs.push_back('{0, 0, 3'b010, 32'h20, 32'h0, 0, 32'h1234FFEF});
        vecs.push_back('{1, 0, 3'b010, 32'h20, 32'h0, 0, 32'h1234FFEF});
        vecs.push_back('{0, 0, 3'b000, 32'h20, 32'h0, 0, 32'hFFFFFFEF});

        // Reset with both requests asserted, including a store to 0x40.
        rst_n = 1'b0;
        if_req = 1'b1; if_addr = 32'h10;
        ls_req = 1'b1; ls_we = 1'b1; ls_funct3 = 3'b010; ls_addr = 32'h40; ls_wdata = 32'hAAAA5555;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (c > 0) begin
                chk("rst_ready", 32'({if_ready, ls_ready}), 32'd0);
                chk("rst_flags", 32'({if_valid, ls_valid, if_err, ls_err}), 32'd0);
                chk("rst_data", if_instr | ls_rdata, 32'd0);
                chk_quiet_mem("rst");
            end
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        drive_idle();

        // Arbitration: data request wins, fetch taken two cycles later.
        @(posedge clk); #1;
        if_req = 1'b1; if_addr = 32'h10;
        ls_req = 1'b1; ls_we = 1'b0; ls_funct3 = 3'b010; ls_addr = 32'h20;
        @(negedge clk);
        chk("arb_ls_ready", 32'(ls_ready), 32'd1);
        chk("arb_if_ready", 32'(if_ready), 32'd0);
        @(posedge clk); #1;
        ls_req = 1'b0;
        @(negedge clk);
        chk("arb_ls_valid", 32'(ls_valid), 32'd1);
        chk("arb_ls_rdata", ls_rdata, 32'hDEADBEEF);
        chk("arb_if_valid_early", 32'(if_valid), 32'd0);
        @(negedge clk);
        chk("arb_if_ready_t2", 32'(if_ready), 32'd1);
        chk("arb_fetch_raddr", mem_read_address, 32'h10);
        @(posedge clk); #1;
        drive_idle();
        @(negedge clk);
        chk("arb_if_valid", 32'(if_valid), 32'd1);
        chk("arb_if_instr", if_instr, 32'h00A00093);
        @(negedge clk);

        foreach (vecs[i]) run_vec(vecs[i], i);

        // Back-to-back loads with the request held high.
        @(posedge clk); #1;
        ls_req = 1'b1; ls_we = 1'b0; ls_funct3 = 3'b010; ls_addr = 32'h10;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk($sformatf("b2b_ready%0d", k), 32'(ls_ready), 32'(k % 2 == 0));
            chk($sformatf("b2b_valid%0d", k), 32'(ls_valid), 32'(k % 2 == 1));
            if (k % 2 == 1) chk($sformatf("b2b_data%0d", k), ls_rdata, 32'h00A00093);
        end
        @(posedge clk); #1;
        drive_idle();
        @(negedge clk);

        // Reset arriving in the response cycle of a load.
        @(posedge clk); #1;
        ls_req = 1'b1; ls_we = 1'b0; ls_funct3 = 3'b010; ls_addr = 32'h20;
        @(negedge clk);
        chk("midrst_accept", 32'(ls_ready), 32'd1);
        @(posedge clk); #1;
        rst_n = 1'b0; drive_idle();
        @(negedge clk);
        chk("midrst_valid", 32'({if_valid, ls_valid, ls_err}), 32'd0);
        chk("midrst_rdata", ls_rdata, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("midrst_idle_ready", 32'(ls_ready), 32'd1);
        chk("midrst_no_late_valid", 32'({if_valid, ls_valid}), 32'd0);
        chk("midrst_holds", ls_rdata | if_instr, 32'd0);

        run_random(600);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
